// File: rtl/lumos_pkg.sv
// Purpose: shared fetch-stage constants and the address type for LumosRV.
// Latency: none (declarations only).
// Backpressure: not applicable.
// Contents: XLEN, PC_INC, RESET_VEC defaults and addr_t.
// Optional feature macro used by importers: ADDR_GEN_ALIGN_EN.
package lumos_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned PC_INC = 4;

  typedef logic [XLEN-1:0] addr_t;

  localparam addr_t RESET_VEC = '0;

endpackage : lumos_pkg

// File: rtl/address_generator_pc_next_mux.sv
// Purpose: combinational next-PC select (reset / redirect target / pc + PC_INC).
// Latency: purely combinational, zero cycles.
// Backpressure: none; a new next-PC is produced every cycle.
// Ports:
//   i_rst        reset request, highest priority
//   i_pc_src     1 = take i_target, 0 = sequential increment
//   i_target     redirect target address
//   i_pc_cur     current registered PC
//   o_pc_next    value to load into the PC register on the next edge
// Config: ADDR_GEN_ALIGN_EN forces the target and reset vector to 4-byte alignment.
module pc_next_mux
  import lumos_pkg::*;
#(
  parameter int unsigned     P_XLEN      = XLEN,
  parameter logic [P_XLEN-1:0] P_RESET_VEC = RESET_VEC,
  parameter int unsigned     P_INC       = PC_INC
) (
  input  logic              i_rst,
  input  logic              i_pc_src,
  input  logic [P_XLEN-1:0] i_target,
  input  logic [P_XLEN-1:0] i_pc_cur,
  output logic [P_XLEN-1:0] o_pc_next
);

  localparam logic [P_XLEN-1:0] L_INC = P_XLEN'(P_INC);

`ifdef ADDR_GEN_ALIGN_EN
  // Low two bits dropped so every redirect lands on an instruction word.
  localparam logic [P_XLEN-1:0] L_RESET = {P_RESET_VEC[P_XLEN-1:2], 2'b00};
  logic [P_XLEN-1:0] w_target;
  assign w_target = {i_target[P_XLEN-1:2], 2'b00};
`else
  localparam logic [P_XLEN-1:0] L_RESET = P_RESET_VEC;
  logic [P_XLEN-1:0] w_target;
  assign w_target = i_target;
`endif

  // Increment wraps modulo 2^XLEN; carry out is intentionally discarded.
  logic [P_XLEN-1:0] w_pc_inc;
  assign w_pc_inc = i_pc_cur + L_INC;

  always_comb begin
    o_pc_next = w_pc_inc;
    if (i_rst) begin
      o_pc_next = L_RESET;
    end else if (i_pc_src) begin
      o_pc_next = w_target;
    end
  end

endmodule : pc_next_mux

// File: rtl/address_generator.sv
// Purpose: LumosRV fetch program counter; advances by PC_INC or loads a redirect target.
// Latency: 1 cycle from pc_src/PCTarget (and rst) to pc; pc is purely registered.
// Backpressure: none; the PC advances on every non-reset edge (no stall input).
// Ports:
//   PCTarget  redirect target address from execute/branch unit
//   clk       single clock, rising edge
//   rst       synchronous active-high reset, loads RESET_VEC
//   pc_src    1 = load PCTarget, 0 = pc + PC_INC
//   pc        current program counter
// Config: ADDR_GEN_ALIGN_EN (see pc_next_mux) aligns target loads and reset vector.
module address_generator
  import lumos_pkg::*;
#(
  parameter int unsigned       XLEN      = lumos_pkg::XLEN,
  parameter logic [XLEN-1:0]   RESET_VEC = lumos_pkg::RESET_VEC,
  parameter int unsigned       PC_INC    = lumos_pkg::PC_INC
) (
  input  logic [XLEN-1:0] PCTarget,
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_src,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;

  // Reset priority lives in the mux, so the register simply loads every edge.
  pc_next_mux #(
    .P_XLEN      (XLEN),
    .P_RESET_VEC (RESET_VEC),
    .P_INC       (PC_INC)
  ) u_pc_next_mux (
    .i_rst     (rst),
    .i_pc_src  (pc_src),
    .i_target  (PCTarget),
    .i_pc_cur  (r_pc),
    .o_pc_next (w_pc_next)
  );

  always_ff @(posedge clk) begin
    r_pc <= w_pc_next;
  end

  assign pc = r_pc;

endmodule : address_generator

// File: tb/tb_address_generator.sv
// Directed stimulus with hand-computed expected PCs pushed into a scoreboard;
// a separate monitor pops and compares once per cycle on the falling edge.
module tb_address_generator;

  logic [31:0] PCTarget;
  logic        clk;
  logic        rst;
  logic        pc_src;
  logic [31:0] pc;

  int tests_run;
  int tests_failed;

  logic [31:0] exp_q[$];
  int          id_q[$];
  int          step_id;

  address_generator dut (
    .PCTarget (PCTarget),
    .clk      (clk),
    .rst      (rst),
    .pc_src   (pc_src),
    .pc       (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge worth of inputs and record the PC expected after that edge.
  task automatic step(input logic r, input logic s, input logic [31:0] t,
                      input logic [31:0] exp_pc);
    @(negedge clk);
    rst      = r;
    pc_src   = s;
    PCTarget = t;
    @(posedge clk);
    #1;
    exp_q.push_back(exp_pc);
    id_q.push_back(step_id);
    step_id++;
  endtask

  // Monitor: the PC is valid every cycle once the first edge has been scored.
  initial begin : monitor
    logic [31:0] e;
    int          id;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        tests_run++;
        if (pc !== e) begin
          tests_failed++;
          $display("FAIL step%0d pc: got 0x%08h expected 0x%08h", id, pc, e);
        end
      end
    end
  end

`ifdef ADDR_GEN_ALIGN_EN
  localparam logic [31:0] TGT_A1 = 32'h0000_00A0;
`else
  localparam logic [31:0] TGT_A1 = 32'h0000_00A1;
`endif

  initial begin : driver
    tests_run    = 0;
    tests_failed = 0;
    step_id      = 0;
    rst          = 1'b1;
    pc_src       = 1'b0;
    PCTarget     = 32'h0000_00A1;

    // Reset for two edges; target present but ignored.
    step(1'b1, 1'b0, 32'h0000_00A1, 32'h0000_0000);
    step(1'b1, 1'b0, 32'h0000_00A1, 32'h0000_0000);

    // Sequential run 0x04 .. 0x28.
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b0, 32'h0000_00A1, 32'(4 * i));
    end

    // Misaligned target load then sequential increments.
    step(1'b0, 1'b1, 32'h0000_00A1, TGT_A1);
    step(1'b0, 1'b0, 32'h0000_00A1, TGT_A1 + 32'h04);
    step(1'b0, 1'b0, 32'h0000_00A1, TGT_A1 + 32'h08);
    step(1'b0, 1'b0, 32'h0000_00A1, TGT_A1 + 32'h0C);

    // Five more sequential edges, then redirect to 0x20.
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b0, 32'h0, TGT_A1 + 32'h0C + 32'(4 * i));
    end
    step(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0020);
    step(1'b0, 1'b0, 32'h0000_0020, 32'h0000_0024);
    step(1'b0, 1'b0, 32'h0000_0020, 32'h0000_0028);

    // pc_src held high with constant target: PC parks on the target.
    step(1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040);
    step(1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040);

    // Wrap at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000);
    step(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0004);

    // Reset asserted together with a redirect: reset wins.
    step(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0000);
    step(1'b0, 1'b0, 32'h0000_0100, 32'h0000_0004);
    step(1'b0, 1'b0, 32'h0000_0100, 32'h0000_0008);

    // Let the monitor drain, bounded to a few cycles.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_address_generator
